simd_skid_reg: RTL

//  Parametrised pipeline stage register for the SIMD DLX datapath; successor to the plain CE register.

---
 rtl/simd_skid_reg_pkg.sv | 33 +++
 rtl/simd_skid_reg_if.sv | 36 +++
 rtl/simd_skid_reg_lane_merge.sv | 41 ++++
 rtl/simd_skid_reg.sv | 127 ++++++++++++
 4 files changed

// File: rtl/simd_skid_reg_pkg.sv
// simd_pkg: shared helpers for the SIMD skid-register slice.
//   lane_width()  - derives the per-lane width from total width and lane count
//   lane_merge()  - selects one lane from the new word or the last accepted word
//   lane_parity() - even parity bit of one lane
//   skid_state_t  - skid buffer occupancy, encoded as {SKID.valid, MAIN.valid}
// Lanes are passed zero-extended to MAX_LANE_W so one function serves every width.
package simd_pkg;

    localparam int unsigned MAX_LANE_W = 1024;

    typedef logic [MAX_LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

    function automatic int unsigned lane_width(input int unsigned w, input int unsigned lanes);
        return w / lanes;
    endfunction

    function automatic lane_t lane_merge(input logic take_new, input lane_t new_lane,
                                         input lane_t old_lane);
        return take_new ? new_lane : old_lane;
    endfunction

    // Zero extension leaves the XOR unchanged, so this is valid for any lane width.
    function automatic logic lane_parity(input lane_t lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/simd_skid_reg_if.sv
// simd_skid_reg_if: valid/ready bus around one simd_skid_reg stage.
//   IN_VALID/IN_READY/IN_DATA/IN_LMASK   upstream handshake, word and lane write mask
//   OUT_VALID/OUT_READY/OUT_DATA          downstream handshake and word
//   OUT_PAR                               per-lane even parity (SIMD_SKID_REG_PARITY_EN only)
// slave = the stage itself, master = the surrounding pipeline / bench.
interface simd_skid_reg_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     IN_DATA;
    logic [LANES-1:0] IN_LMASK;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [W-1:0]     OUT_DATA;
`ifdef SIMD_SKID_REG_PARITY_EN
    logic [LANES-1:0] OUT_PAR;
`endif

    modport slave (
        input  IN_VALID, IN_DATA, IN_LMASK, OUT_READY,
`ifdef SIMD_SKID_REG_PARITY_EN
        output OUT_PAR,
`endif
        output IN_READY, OUT_VALID, OUT_DATA
    );

    modport master (
        output IN_VALID, IN_DATA, IN_LMASK, OUT_READY,
`ifdef SIMD_SKID_REG_PARITY_EN
        input  OUT_PAR,
`endif
        input  IN_READY, OUT_VALID, OUT_DATA
    );
endinterface

// File: rtl/simd_skid_reg_lane_merge.sv
// simd_lane_merge: combinational per-lane merge of a new word with the last accepted word.
//   IN_DATA  in  W      new word
//   LAST     in  W      last accepted merged word
//   LMASK    in  LANES  1 = lane from IN_DATA, 0 = lane from LAST
//   MERGED   out W      merged word
//   PAR      out LANES  per-lane even parity of MERGED (SIMD_SKID_REG_PARITY_EN only)
module simd_lane_merge
    import simd_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 4
) (
    input  logic [W-1:0]     IN_DATA,
    input  logic [W-1:0]     LAST,
    input  logic [LANES-1:0] LMASK,
`ifdef SIMD_SKID_REG_PARITY_EN
    output logic [LANES-1:0] PAR,
`endif
    output logic [W-1:0]     MERGED
);
    localparam int unsigned LANE_W = lane_width(W, LANES);

    logic [LANE_W-1:0] lane;

    always_comb begin
        MERGED = '0;
        lane   = '0;
`ifdef SIMD_SKID_REG_PARITY_EN
        PAR    = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            lane = LANE_W'(lane_merge(LMASK[i],
                                      MAX_LANE_W'(IN_DATA[i*LANE_W +: LANE_W]),
                                      MAX_LANE_W'(LAST[i*LANE_W +: LANE_W])));
            MERGED[i*LANE_W +: LANE_W] = lane;
`ifdef SIMD_SKID_REG_PARITY_EN
            PAR[i] = lane_parity(MAX_LANE_W'(lane));
`endif
        end
    end
endmodule

// File: rtl/simd_skid_reg.sv
// simd_skid_reg: lane-masked pipeline register with a 2-entry skid buffer.
//   CLK    in  clock, all state on posedge
//   RESET  in  synchronous active-high reset (drops entries, clears LAST/data)
//   FLUSH  in  synchronous squash of buffered entries (data and LAST retained)
//   bus    simd_skid_reg_if.slave: IN_* upstream, OUT_* downstream
// IN_READY and OUT_VALID come straight from the state register.
// Optional feature macro: SIMD_SKID_REG_PARITY_EN adds stored per-lane parity on OUT_PAR.
module simd_skid_reg
    import simd_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 4
) (
    input logic           CLK,
    input logic           RESET,
    input logic           FLUSH,
    simd_skid_reg_if.slave bus
);
    localparam int unsigned LANE_W = lane_width(W, LANES);

    if ((W % LANES) != 0) begin : g_bad_lanes
        $error("simd_skid_reg: W must be a multiple of LANES");
    end
    if (LANE_W > MAX_LANE_W) begin : g_bad_lane_w
        $error("simd_skid_reg: lane width exceeds MAX_LANE_W");
    end

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, skid_q, last_q, merged;
    logic         acc, deq, ld_main_in, ld_main_skid, ld_skid;

`ifdef SIMD_SKID_REG_PARITY_EN
    logic [LANES-1:0] merged_par, main_par_q, skid_par_q;
`endif

    simd_lane_merge #(.W(W), .LANES(LANES)) u_merge (
        .IN_DATA (bus.IN_DATA),
        .LAST    (last_q),
        .LMASK   (bus.IN_LMASK),
`ifdef SIMD_SKID_REG_PARITY_EN
        .PAR     (merged_par),
`endif
        .MERGED  (merged)
    );

    always_comb begin
        bus.IN_READY  = (state_q != FULL);
        bus.OUT_VALID = (state_q != EMPTY);
        bus.OUT_DATA  = main_q;
`ifdef SIMD_SKID_REG_PARITY_EN
        bus.OUT_PAR   = main_par_q;
`endif
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        acc          = bus.IN_VALID && (state_q != FULL);
        deq          = (state_q != EMPTY) && bus.OUT_READY;
        case (state_q)
            EMPTY: if (acc) begin
                ld_main_in = 1'b1;
                state_d    = ONE;
            end
            ONE: begin
                if (acc && deq) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    ld_skid = 1'b1;
                    state_d = FULL;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (deq) begin
                ld_main_skid = 1'b1;
                state_d      = ONE;
            end
            default: state_d = EMPTY;
        endcase
        // Squash: handshakes still complete, but nothing is loaded.
        if (FLUSH) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            last_q  <= '0;
`ifdef SIMD_SKID_REG_PARITY_EN
            main_par_q <= '0;
            skid_par_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (ld_main_in) begin
                main_q <= merged;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= merged;
            end
            if (acc && !FLUSH) begin
                last_q <= merged;
            end
`ifdef SIMD_SKID_REG_PARITY_EN
            if (ld_main_in) begin
                main_par_q <= merged_par;
            end else if (ld_main_skid) begin
                main_par_q <= skid_par_q;
            end
            if (ld_skid) begin
                skid_par_q <= merged_par;
            end
`endif
        end
    end
endmodule
